// File: rtl/fifo_rd_arbiter.sv
// ============================================================================
// fifo_rd_arbiter
// ----------------------------------------------------------------------------
// Shares the read port of one async FIFO (read side already in the clk_r
// domain) among NUM_REQ consumers. Consumers are served in round-robin order.
// Each grant allows a burst of up to MAX_BURST reads. Data for every read
// strobe comes back two cycles later, tagged with the consumer index.
//
// Parameters
//   DATA_WIDTH : width of the FIFO read data
//   NUM_REQ    : number of consumers (>= 2)
//   MAX_BURST  : maximum number of FIFO reads per grant
//
// Ports
//   clk_r        in   read-domain clock; all state changes on its rising edge
//   arst         in   asynchronous reset, active low
//   req_i        in   per-consumer read request, level sensitive
//   fifo_empty_i in   FIFO empty flag (clk_r domain)
//   fifo_rdata_i in   FIFO read data, valid in the cycle after a read strobe
//   fifo_re_o    out  FIFO read strobe (combinational in BURST)
//   gnt_o        out  one-hot registered grant, all zero when idle
//   rvalid_o     out  returned-data valid
//   rdata_o      out  returned data (zero when rvalid_o is low)
//   rid_o        out  consumer index owning rdata_o (zero when rvalid_o is low)
//
// FSM states
//   state | meaning
//   IDLE  | no grant; pick the next requester when the FIFO has data
//   BURST | one consumer granted; strobe reads while it requests and data
//         | is available, up to MAX_BURST reads
// ============================================================================
module fifo_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk_r,
    input  logic                       arst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]      fifo_rdata_i,
    output logic                       fifo_re_o,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       rvalid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic [$clog2(NUM_REQ)-1:0] rid_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [IW-1:0]       gidx_q, gidx_d;     // granted index, valid in BURST
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]       last_q, last_d;     // round-robin pointer
    logic [CW-1:0]       cnt_q, cnt_d;       // reads issued in this burst

    // ------------------------------------------------------------------
    // Return pipeline: stage 1 carries the strobe and its owner while the
    // FIFO drives the data, stage 2 presents the captured word.
    // ------------------------------------------------------------------
    logic                  re_p1;
    logic [IW-1:0]         id_p1;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IW-1:0]         rid_q;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester strictly after last_q, wrapping.
    // Offset NUM_REQ wraps back onto last_q itself, so the previous owner
    // is only chosen again when nobody else is requesting.
    // ------------------------------------------------------------------
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] cand_idx;
    int            cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_q) + k) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!sel_found && req_i[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register (process 1 of 3)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_r or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (process 2 of 3)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (sel_found && !fifo_empty_i) begin
                    state_d = BURST;
                    gidx_d  = sel_idx;
                    gnt_d   = NUM_REQ'(1) << sel_idx;
                    cnt_d   = '0;
                end
            end

            BURST: begin
                if (fifo_re_o) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Any cycle without a strobe closes the burst, as does the
                // last allowed read. Either way one IDLE cycle follows.
                if (!fifo_re_o || (cnt_q == MAX_CNT - CW'(1))) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (process 3 of 3)
    // ------------------------------------------------------------------
    always_comb begin
        fifo_re_o = 1'b0;
        if (state_q == BURST) begin
            fifo_re_o = req_i[gidx_q] && !fifo_empty_i && (cnt_q < MAX_CNT);
        end
    end

    assign gnt_o = gnt_q;

    // ------------------------------------------------------------------
    // Return pipeline. Runs independently of the FSM so strobes issued at
    // the end of a burst still come back during IDLE or the next burst.
    // Reset flushes both stages, discarding any in-flight returns.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_r or negedge arst) begin
        if (!arst) begin
            re_p1    <= 1'b0;
            id_p1    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            re_p1    <= fifo_re_o;
            id_p1    <= fifo_re_o ? gidx_q : '0;
            rvalid_q <= re_p1;
            rdata_q  <= re_p1 ? fifo_rdata_i : '0;
            rid_q    <= re_p1 ? id_p1 : '0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rid_o    = rid_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// ============================================================================
// tb_fifo_rd_arbiter
// ----------------------------------------------------------------------------
// Bench for fifo_rd_arbiter. A queue models the FIFO contents; a monitor on
// the falling edge predicts grants, strobes and returns from the arbitration
// rules (round-robin pick, burst limit, two-cycle return) and compares every
// cycle. Scenario tasks add their own end-of-scenario checks on logs.
// ============================================================================
module tb_fifo_rd_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic              clk_r = 1'b0;
    logic              arst  = 1'b0;
    logic [NR-1:0]     req_i = '0;
    logic              fifo_empty_i = 1'b1;
    logic [DW-1:0]     fifo_rdata_i = '0;
    logic              fifo_re_o;
    logic [NR-1:0]     gnt_o;
    logic              rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic [IW-1:0]     rid_o;

    fifo_rd_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk_r        (clk_r),
        .arst         (arst),
        .req_i        (req_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_re_o    (fifo_re_o),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rid_o        (rid_o)
    );

    always #5 clk_r = ~clk_r;

    int checks = 0;
    int errors = 0;

    // FIFO model
    logic [DW-1:0] fq[$];
    logic [DW-1:0] pushed[$];
    logic          pend = 1'b0;
    logic [DW-1:0] pend_data = '0;

    // Reference model state
    int            m_last = NR - 1;
    int            m_g = -1;
    int            m_cnt = 0;
    bit            prev_ok = 0;
    int            prev_g = -1;
    logic [NR-1:0] prev_req = '0;
    bit            prev_empty = 1;
    bit            prev_re = 0;
    bit            p1_v = 0, p2_v = 0;
    logic [IW-1:0] p1_id = '0, p2_id = '0;
    logic [DW-1:0] p1_d = '0, p2_d = '0;

    // Logs
    int            gnt_log[$];
    int            blen_log[$];
    int            rx_id[$];
    logic [DW-1:0] rx_d[$];
    int            strobes = 0;

    function automatic int rr_pick(int last, logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // FIFO side: data of a strobe in cycle N is driven during cycle N+1,
    // empty flag follows queue occupancy.
    always @(posedge clk_r) begin
        #2;
        fifo_rdata_i = pend ? pend_data : $urandom;
        pend = 1'b0;
        fifo_empty_i = (fq.size() == 0);
    end

    // Cycle monitor / reference model
    always @(negedge clk_r) begin
        int   gd;
        logic exp_re;
        if (!arst) begin
            prev_ok = 0;
            m_g = -1;
            m_cnt = 0;
            m_last = NR - 1;
            p1_v = 0;
            p2_v = 0;
        end else begin
            gd = -1;
            for (int i = 0; i < NR; i++) if (gnt_o[i]) gd = i;

            checks++;
            if ($countones(gnt_o) > 1) begin
                errors++;
                $display("FAIL gnt_onehot: got %b required at most one bit", gnt_o);
            end

            checks++;
            if (rvalid_o !== p2_v ||
                (p2_v && (rid_o !== p2_id || rdata_o !== p2_d)) ||
                (!p2_v && (rid_o !== '0 || rdata_o !== '0))) begin
                errors++;
                $display("FAIL return: got v=%b id=%0d d=%h required v=%b id=%0d d=%h",
                         rvalid_o, rid_o, rdata_o, p2_v, p2_v ? p2_id : '0, p2_v ? p2_d : '0);
            end
            if (rvalid_o) begin
                rx_id.push_back(int'(rid_o));
                rx_d.push_back(rdata_o);
            end

            if (prev_ok) begin
                if (prev_g < 0) begin
                    if (prev_req != 0 && !prev_empty) begin
                        m_g = rr_pick(m_last, prev_req);
                        m_cnt = 0;
                        gnt_log.push_back(m_g);
                    end
                end else if (!prev_re || m_cnt >= MB) begin
                    blen_log.push_back(m_cnt);
                    m_last = prev_g;
                    m_g = -1;
                end
            end

            checks++;
            if (gd !== m_g) begin
                errors++;
                $display("FAIL grant: got %0d required %0d (-1 = none)", gd, m_g);
            end

            exp_re = (m_g >= 0) && req_i[m_g] && !fifo_empty_i && (m_cnt < MB);
            checks++;
            if (fifo_re_o !== exp_re) begin
                errors++;
                $display("FAIL read_strobe: got %b required %b", fifo_re_o, exp_re);
            end

            p2_v = p1_v;
            p2_id = p1_id;
            p2_d = p1_d;
            p1_v = fifo_re_o;
            if (fifo_re_o) begin
                m_cnt++;
                strobes++;
                p1_id = IW'(m_g < 0 ? 0 : m_g);
                p1_d = (fq.size() > 0) ? fq.pop_front() : '0;
                pend = 1'b1;
                pend_data = p1_d;
            end

            prev_ok = 1;
            prev_g = m_g;
            prev_req = req_i;
            prev_empty = fifo_empty_i;
            prev_re = fifo_re_o;
        end
    end

    task automatic clear_logs();
        gnt_log.delete();
        blen_log.delete();
        rx_id.delete();
        rx_d.delete();
        pushed.delete();
        strobes = 0;
    endtask

    task automatic push_words(int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fq.push_back(w);
            pushed.push_back(w);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_r); #1;
        arst = 1'b0;
        req_i = '0;
        fq.delete();
        repeat (3) @(posedge clk_r);
        #1;
        arst = 1'b1;
        clear_logs();
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk_r);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b0;
        req_i = 4'hF;
        push_words(3);
        repeat (3) @(posedge clk_r);
        @(negedge clk_r);
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b required 0", gnt_o); end
        checks++; if (fifo_re_o !== 1'b0) begin errors++; $display("FAIL reset_re: got %b required 0", fifo_re_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b required 0", rvalid_o); end
        checks++; if (rdata_o !== '0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rdata_o); end
        checks++; if (rid_o !== '0) begin errors++; $display("FAIL reset_rid: got %0d required 0", rid_o); end
    endtask

    task automatic test_single();
        int bad;
        do_reset();
        push_words(6);
        req_i = 4'b0001;
        run(16);
        req_i = '0;
        run(4);
        checks++;
        if (blen_log.size() != 2 || blen_log[0] != 4 || blen_log[1] != 2) begin
            errors++;
            $display("FAIL single_bursts: got %0d bursts (first %0d) required 2 bursts of 4,2",
                     blen_log.size(), blen_log.size() > 0 ? blen_log[0] : -1);
        end
        bad = 0;
        for (int i = 0; i < rx_id.size(); i++)
            if (rx_id[i] != 0 || i >= pushed.size() || rx_d[i] !== pushed[i]) bad++;
        checks++;
        if (rx_id.size() != 6 || bad != 0) begin
            errors++;
            $display("FAIL single_data: got %0d words (%0d wrong) required 6 in order id 0",
                     rx_id.size(), bad);
        end
    endtask

    task automatic test_fairness();
        int cnt[NR];
        do_reset();
        push_words(16);
        req_i = 4'hF;
        run(30);
        req_i = '0;
        run(4);
        checks++;
        if (gnt_log.size() != 4 || gnt_log[0] != 0 || gnt_log[1] != 1 ||
            gnt_log[2] != 2 || gnt_log[3] != 3) begin
            errors++;
            $display("FAIL fair_order: got %0d grants required order 0,1,2,3", gnt_log.size());
        end
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int i = 0; i < rx_id.size(); i++) cnt[rx_id[i]]++;
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (cnt[i] != 4) begin
                errors++;
                $display("FAIL fair_words: consumer %0d got %0d words required 4", i, cnt[i]);
            end
        end
    endtask

    task automatic test_empty_mid();
        do_reset();
        push_words(1);
        req_i = 4'b0010;
        run(6);
        req_i = 4'b1100;
        push_words(2);
        run(8);
        push_words(4);
        run(10);
        req_i = '0;
        run(4);
        checks++;
        if (gnt_log.size() != 3 || gnt_log[0] != 1 || gnt_log[1] != 2 || gnt_log[2] != 3) begin
            errors++;
            $display("FAIL empty_grants: got %0d grants required 1,2,3", gnt_log.size());
        end
        checks++;
        if (blen_log.size() != 3 || blen_log[1] != 2 || blen_log[2] != 4) begin
            errors++;
            $display("FAIL empty_bursts: got %0d bursts required lengths 1,2,4", blen_log.size());
        end
    endtask

    task automatic test_withdraw();
        int n1;
        bit seen;
        do_reset();
        push_words(8);
        req_i = 4'b0010;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_r);
            if (fifo_re_o) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL withdraw_timeout: got no strobe required one within 10 cycles");
        end
        @(posedge clk_r); #1;
        req_i = 4'b0101;
        run(14);
        req_i = '0;
        run(4);
        n1 = 0;
        for (int i = 0; i < rx_id.size(); i++) if (rx_id[i] == 1) n1++;
        checks++;
        if (n1 != 1) begin
            errors++;
            $display("FAIL withdraw_words: consumer 1 got %0d words required 1", n1);
        end
        checks++;
        if (gnt_log.size() < 2 || gnt_log[0] != 1 || gnt_log[1] != 2) begin
            errors++;
            $display("FAIL withdraw_next: got %0d grants required 1 then 2", gnt_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int nv;
        do_reset();
        push_words(8);
        req_i = 4'b0001;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_r);
            if (fifo_re_o) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_timeout: got no strobe required one within 10 cycles");
        end
        @(posedge clk_r); #1;
        arst = 1'b0;
        #1;
        checks++;
        if (gnt_o !== '0 || fifo_re_o !== 1'b0 || rvalid_o !== 1'b0 ||
            rdata_o !== '0 || rid_o !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got gnt=%b re=%b v=%b d=%h id=%0d required all 0",
                     gnt_o, fifo_re_o, rvalid_o, rdata_o, rid_o);
        end
        req_i = '0;
        fq.delete();
        repeat (3) @(posedge clk_r);
        #1;
        arst = 1'b1;
        clear_logs();
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_r);
            if (rvalid_o) nv++;
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL rstmid_flush: got %0d rvalid pulses required 0", nv);
        end
        @(posedge clk_r); #1;
        push_words(4);
        req_i = 4'hF;
        run(10);
        req_i = '0;
        run(4);
        checks++;
        if (gnt_log.size() < 1 || gnt_log[0] != 0) begin
            errors++;
            $display("FAIL rstmid_first: got %0d required 0",
                     gnt_log.size() > 0 ? gnt_log[0] : -1);
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk_r); #1;
            req_i = NR'($urandom);
            if ($urandom_range(0, 3) == 0 && fq.size() < 20)
                push_words(int'($urandom_range(1, 5)));
        end
        req_i = '0;
        run(6);
        checks++;
        if (rx_id.size() != strobes) begin
            errors++;
            $display("FAIL rand_count: got %0d returns required %0d", rx_id.size(), strobes);
        end
        bad = 0;
        for (int i = 0; i < rx_d.size(); i++)
            if (i >= pushed.size() || rx_d[i] !== pushed[i]) bad++;
        checks++;
        if (bad != 0 || rx_d.size() == 0) begin
            errors++;
            $display("FAIL rand_order: got %0d out-of-order of %0d words required 0 of >0",
                     bad, rx_d.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_empty_mid();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
